gcd_req_driver: RTL and testbench

- Requester-side engine for the GCD unit handshake (operand_A/operand_B/input_available in, result_data/result_rdy/result_taken out).
- Buffers host operand pairs in an input FIFO, issues them one at a time to the GCD unit, and collects results into an output FIFO for the host.
- Measures per-operation latency.
- Sits between a host/bus adapter and gcd_rtl_top. Both blocks share clk and reset.

---
 rtl/gcd_req_driver_if.sv | 30 +++
 rtl/gcd_req_driver.sv | 165 ++++++++++++++++
 tb/tb_gcd_req_driver.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_req_driver_if.sv
// Handshake between the requester engine and the GCD unit.
// The driver is the master; the GCD unit (or its stand-in) is the slave.
interface gcd_req_driver_if #(
  parameter int W = 16
);
  logic [W-1:0] operand_A;
  logic [W-1:0] operand_B;
  logic         input_available;
  logic [W-1:0] result_data;
  logic         result_rdy;
  logic         result_taken;

  modport master (
    output operand_A,
    output operand_B,
    output input_available,
    output result_taken,
    input  result_data,
    input  result_rdy
  );

  modport slave (
    input  operand_A,
    input  operand_B,
    input  input_available,
    input  result_taken,
    output result_data,
    output result_rdy
  );
endinterface

// File: rtl/gcd_req_driver.sv
// Requester engine for the GCD unit: buffers host operand pairs, issues one op at a time,
// queues results for the host and records per-operation latency and completion count.
module gcd_req_driver #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [W-1:0]          op_a,
  input  logic [W-1:0]          op_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [W-1:0]          res_data,
  gcd_req_driver_if.master      gcd,
  output logic                  busy,
  output logic [15:0]           last_latency,
  output logic [15:0]           done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, TAKE} state_t;

  state_t          state_reg;
  logic [W-1:0]    operand_a_reg;
  logic [W-1:0]    operand_b_reg;
  logic            input_available_reg;
  logic            result_taken_reg;
  logic [15:0]     lat_cnt_reg;
  logic [15:0]     last_latency_reg;
  logic [15:0]     done_count_reg;

  logic [W-1:0]    opa_mem [DEPTH];
  logic [W-1:0]    opb_mem [DEPTH];
  logic [AW-1:0]   opf_wr_ptr_reg;
  logic [AW-1:0]   opf_rd_ptr_reg;
  logic [CW-1:0]   opf_count_reg;

  logic [W-1:0]    res_mem [DEPTH];
  logic [AW-1:0]   resf_wr_ptr_reg;
  logic [AW-1:0]   resf_rd_ptr_reg;
  logic [AW-1:0]   resf_rd_ptr_next;
  logic [CW-1:0]   resf_count_reg;
  logic [W-1:0]    res_data_reg;

  logic            op_push;
  logic            issue;
  logic            res_push;
  logic            res_pop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign op_ready  = (opf_count_reg != CW'(DEPTH));
  assign res_valid = (resf_count_reg != '0);
  assign op_push   = op_valid && op_ready;
  assign res_pop   = res_valid && res_ready;
  // Issuing needs a free result slot so the capture in WAIT_RES can never overflow.
  assign issue     = (state_reg == IDLE) && (opf_count_reg != '0) &&
                     (resf_count_reg != CW'(DEPTH));
  assign res_push  = (state_reg == WAIT_RES) && gcd.result_rdy;
  assign resf_rd_ptr_next = resf_rd_ptr_reg + AW'(res_pop);

  assign gcd.operand_A       = operand_a_reg;
  assign gcd.operand_B       = operand_b_reg;
  assign gcd.input_available = input_available_reg;
  assign gcd.result_taken    = result_taken_reg;
  assign res_data            = res_data_reg;
  assign busy                = (state_reg != IDLE);
  assign last_latency        = last_latency_reg;
  assign done_count          = done_count_reg;

  always_ff @(posedge clk) begin
    if (op_push) begin
      opa_mem[opf_wr_ptr_reg] <= op_a;
      opb_mem[opf_wr_ptr_reg] <= op_b;
    end
  end

  // Result storage with a registered head; an entry written into an (about to be) empty
  // FIFO bypasses the array so res_data is valid in the same cycle as res_valid.
  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[resf_wr_ptr_reg] <= gcd.result_data;
    end
    if (res_push && ((resf_count_reg == '0) ||
                     ((resf_count_reg == CW'(1)) && res_pop))) begin
      res_data_reg <= gcd.result_data;
    end else begin
      res_data_reg <= res_mem[resf_rd_ptr_next];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opf_wr_ptr_reg  <= '0;
      opf_rd_ptr_reg  <= '0;
      opf_count_reg   <= '0;
      resf_wr_ptr_reg <= '0;
      resf_rd_ptr_reg <= '0;
      resf_count_reg  <= '0;
    end else begin
      if (op_push) begin
        opf_wr_ptr_reg <= opf_wr_ptr_reg + AW'(1);
      end
      if (issue) begin
        opf_rd_ptr_reg <= opf_rd_ptr_reg + AW'(1);
      end
      opf_count_reg <= opf_count_reg + CW'(op_push) - CW'(issue);
      if (res_push) begin
        resf_wr_ptr_reg <= resf_wr_ptr_reg + AW'(1);
      end
      resf_rd_ptr_reg <= resf_rd_ptr_next;
      resf_count_reg  <= resf_count_reg + CW'(res_push) - CW'(res_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg           <= IDLE;
      operand_a_reg       <= '0;
      operand_b_reg       <= '0;
      input_available_reg <= 1'b0;
      result_taken_reg    <= 1'b0;
      lat_cnt_reg         <= '0;
      last_latency_reg    <= '0;
      done_count_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (issue) begin
            operand_a_reg       <= opa_mem[opf_rd_ptr_reg];
            operand_b_reg       <= opb_mem[opf_rd_ptr_reg];
            input_available_reg <= 1'b1;
            lat_cnt_reg         <= '0;
            state_reg           <= ISSUE;
          end
        end
        ISSUE: begin
          input_available_reg <= 1'b0;
          state_reg           <= WAIT_RES;
        end
        WAIT_RES: begin
          lat_cnt_reg <= sat_inc(lat_cnt_reg);
          if (gcd.result_rdy) begin
            last_latency_reg <= sat_inc(lat_cnt_reg);
            result_taken_reg <= 1'b1;
            state_reg        <= TAKE;
          end
        end
        TAKE: begin
          result_taken_reg <= 1'b0;
          done_count_reg   <= done_count_reg + 16'd1;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_driver.sv
// Bench for gcd_req_driver: a behavioural GCD unit responder with variable latency,
// directed and random host traffic, and queue-based expected results and latencies.
module tb_gcd_req_driver;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic           op_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           busy;
  logic [15:0]    last_latency;
  logic [15:0]    done_count;

  gcd_req_driver_if #(.W(W)) g ();

  gcd_req_driver #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .gcd          (g),
    .busy         (busy),
    .last_latency (last_latency),
    .done_count   (done_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          exp_done;

  logic        rr_main;
  logic        rr_rand;
  logic        rand_rr;
  assign res_ready = rand_rr ? rr_rand : rr_main;

  // GCD unit stand-in: latches on input_available, raises result_rdy after d cycles,
  // holds it until result_taken. Driver latency is then d+1 cycles.
  int          m_state;
  int          m_cnt;
  logic        m_rdy;
  logic [W-1:0] m_res;
  logic        force_rdy;
  int          fixed_delay;
  int          next_d;
  assign g.result_rdy  = m_rdy | force_rdy;
  assign g.result_data = m_res;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    next_d  <= (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
    rr_rand <= 1'($urandom_range(0, 1));
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_rdy   <= 1'b0;
      m_res   <= '0;
    end else begin
      case (m_state)
        0: if (g.input_available) begin
             exp_lat_q.push_back(next_d + 1);
             m_res   <= ref_gcd(g.operand_A, g.operand_B);
             m_cnt   <= next_d;
             m_state <= 1;
           end
        1: if (m_cnt == 1) begin
             m_rdy   <= 1'b1;
             m_state <= 2;
           end else begin
             m_cnt <= m_cnt - 1;
           end
        default: if (g.result_taken) begin
             m_rdy   <= 1'b0;
             m_state <= 0;
           end
      endcase
    end
  end

  // Output monitor: result order/data, pulse widths, latency per completed op.
  logic prev_ia = 1'b0;
  logic prev_rt = 1'b0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_ia <= 1'b0;
      prev_rt <= 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) begin
          check("res_unexpected", 32'(1), 32'(0));
        end else begin
          $display("pop res_data=%0d expected=%0d", res_data, exp_res_q[0]);
          check("res_data", 32'(res_data), 32'(exp_res_q[0]));
          void'(exp_res_q.pop_front());
        end
      end
      if (prev_ia) check("ia_pulse", 32'(g.input_available), 32'(0));
      if (prev_rt) check("rt_pulse", 32'(g.result_taken), 32'(0));
      if (g.result_taken && !prev_rt) begin
        if (exp_lat_q.size() == 0) begin
          check("take_unexpected", 32'(1), 32'(0));
        end else begin
          check("last_latency", 32'(last_latency), 32'(exp_lat_q[0]));
          void'(exp_lat_q.pop_front());
        end
      end
      prev_ia <= g.input_available;
      prev_rt <= g.result_taken;
    end
  end

  // Tasks are entered and left just after a falling edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    while (!op_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", 32'(t >= 500), 32'(0));
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    exp_res_q.push_back(ref_gcd(a, b));
    exp_done++;
    $display("push a=%0d b=%0d", a, b);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_res_q.size() != 0 || busy || res_valid || op_ready !== 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t >= 3000), 32'(0));
    check("drain_done_count", 32'(done_count), 32'(exp_done & 16'hFFFF));
    check("drain_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_op_ready"}, 32'(op_ready), 32'(1));
    check({tag, "_res_valid"}, 32'(res_valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ia"}, 32'(g.input_available), 32'(0));
    check({tag, "_rt"}, 32'(g.result_taken), 32'(0));
    check({tag, "_opA"}, 32'(g.operand_A), 32'(0));
    check({tag, "_opB"}, 32'(g.operand_B), 32'(0));
    check({tag, "_lat"}, 32'(last_latency), 32'(0));
    check({tag, "_done"}, 32'(done_count), 32'(0));
  endtask

  initial begin
    int t;
    logic [15:0] k;
    reset       = 1'b1;
    op_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    rr_main     = 1'b1;
    rand_rr     = 1'b0;
    force_rdy   = 1'b0;
    fixed_delay = 3;
    exp_done    = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Basic operations with res_ready held high.
    push(16'd27, 16'd15);
    wait_drain("drain_27_15");
    fixed_delay = 1;
    push(16'd5, 16'd0);
    wait_drain("drain_5_0");
    check("lat_5_0", 32'(last_latency), 32'(2));
    fixed_delay = 0;
    push(16'd0, 16'd0);
    push(16'd0, 16'd9);
    push(16'hFFFF, 16'hFFFF);
    wait_drain("drain_edge");

    // Fill both FIFOs with the host not popping.
    rr_main = 1'b0;
    push(16'd12, 16'd8);
    push(16'd21, 16'd14);
    push(16'd17, 16'd5);
    push(16'd100, 16'd75);
    push(16'd48, 16'd36);
    push(16'd81, 16'd27);
    push(16'd1, 16'd1);
    push(16'd1000, 16'd10);
    repeat (80) @(negedge clk);
    check("full_op_ready", 32'(op_ready), 32'(0));
    check("full_res_valid", 32'(res_valid), 32'(1));
    check("full_busy", 32'(busy), 32'(0));
    check("full_done", 32'(done_count), 32'((exp_done - 4) & 16'hFFFF));
    check("full_head", 32'(res_data), 32'(4));
    repeat (3) @(negedge clk);
    check("full_head_stable", 32'(res_data), 32'(4));
    check("full_no_issue", 32'(done_count), 32'((exp_done - 4) & 16'hFFFF));
    rr_main = 1'b1;
    wait_drain("drain_full");

    // Asynchronous reset in the middle of WAIT_RES.
    fixed_delay = 6;
    push(16'd27, 16'd15);
    t = 0;
    while (!g.input_available && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_issue_timeout", 32'(t >= 100), 32'(0));
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'(1));
    check("mid_opA", 32'(g.operand_A), 32'(27));
    #3;
    reset = 1'b1;
    exp_res_q.delete();
    exp_lat_q.delete();
    exp_done = 0;
    #1;
    check_reset_state("async");
    @(negedge clk);
    reset = 1'b0;
    fixed_delay = 2;
    push(16'd9, 16'd6);
    wait_drain("drain_after_reset");
    check("after_reset_done", 32'(done_count), 32'(1));

    // Spurious result_rdy while idle with nothing queued.
    force_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("spurious_rt", 32'(g.result_taken), 32'(0));
      check("spurious_res_valid", 32'(res_valid), 32'(0));
    end
    force_rdy = 1'b0;
    @(negedge clk);
    check("spurious_done", 32'(done_count), 32'(1));

    // Random traffic with a randomly stalling host.
    fixed_delay = 0;
    rand_rr     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      k = 16'($urandom_range(1, 200));
      push(16'(k * 16'($urandom_range(0, 300))), 16'(k * 16'($urandom_range(0, 300))));
    end
    wait_drain("drain_random");
    rand_rr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
